// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the ID-stage branch hazard controller.
//   - Branch opcode encodings driven by the decoder (3 bits).
//   - Tnew field width and the two producer latencies.
//   - Scoreboard entry type used for the EX and MEM in-flight writers.
//   - Small decode helpers so the top and the compare unit agree on what
//     counts as a branch and which operands it reads.
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] BR_NONE    = 3'd0;
    localparam logic [2:0] BR_GEZ_LTZ = 3'd1;
    localparam logic [2:0] BR_GTZ     = 3'd2;
    localparam logic [2:0] BR_LEZ     = 3'd3;
    localparam logic [2:0] BR_NE      = 3'd4;
    localparam logic [2:0] BR_EQ      = 3'd5;

    localparam int TNEW_W = 2;

    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

    // One in-flight register writer. tnew counts the cycles still needed
    // before its result can be forwarded back into ID.
    typedef struct packed {
        logic              valid;
        logic [4:0]        dst;
        logic [TNEW_W-1:0] tnew;
    } sb_entry_t;

    // Encodings 6 and 7 are deliberately treated as "no branch".
    function automatic logic br_is_branch(input logic [2:0] op);
        return (op >= BR_GEZ_LTZ) && (op <= BR_EQ);
    endfunction

    // Only the two-register compares read rt.
    function automatic logic br_uses_rt(input logic [2:0] op);
        return (op == BR_NE) || (op == BR_EQ);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Purely combinational branch condition evaluator. All magnitude compares are
// two's-complement signed 32-bit.
//
// Ports:
//   op    in  3   branch opcode (branch_pkg BR_* encodings)
//   judge in  1   for BR_GEZ_LTZ: 1 = bgez, 0 = bltz
//   rs    in  32  forwarded rs value
//   rt    in  32  forwarded rt value
//   cond  out 1   branch condition holds (0 for non-branch opcodes)
// -----------------------------------------------------------------------------
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        judge,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        cond
);

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;

    assign rs_s = $signed(rs);
    assign rt_s = $signed(rt);

    always_comb begin
        cond = 1'b0;
        case (op)
            BR_GEZ_LTZ: cond = judge ? (rs_s >= 32'sd0) : (rs_s < 32'sd0);
            BR_GTZ:     cond = (rs_s >  32'sd0);
            BR_LEZ:     cond = (rs_s <= 32'sd0);
            BR_NE:      cond = (rs_s != rt_s);
            BR_EQ:      cond = (rs_s == rt_s);
            default:    cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
// Resolves branches in the ID stage of a five-stage MIPS pipeline. Branches
// consume their operands in ID (Tuse = 0), so any older writer in EX or MEM
// whose result is not yet forwardable forces ID/IF to stall. A two-entry
// Tnew scoreboard tracks those writers; once no operand is blocked the
// condition is evaluated and the taken decision goes to the NPC logic.
//
// Build option:
//   FLUSH_ON_TAKEN_EN  when defined, adds output if_flush (= branch_taken) so
//                      IF/ID loads a nop and the branch has no delay slot.
//                      When undefined, the slot instruction always executes.
//
// Parameters:
//   STALL_CNT_W  width of the saturating hazard-stall counter
//   TNEW_W       width of Tnew fields
//
// Ports:
//   clk           in   pipeline clock
//   reset_n       in   asynchronous active-low reset
//   ext_stall     in   global freeze; scoreboard and counter hold
//   id_branch_op  in   branch opcode of the instruction in ID
//   id_judge      in   bgez (1) / bltz (0) select for opcode 1
//   id_rs_addr    in   rs register number
//   id_rt_addr    in   rt register number (opcodes 4, 5 only)
//   id_rs_val     in   forwarded rs value
//   id_rt_val     in   forwarded rt value
//   id_wr_en      in   ID instruction writes the GPR file
//   id_wr_addr    in   ID instruction destination
//   id_tnew       in   cycles after entering EX until result is forwardable
//   stall         out  hold PC and IF/ID, bubble into EX
//   branch_taken  out  redirect NPC to the branch target
//   stall_cycles  out  saturating count of hazard-stall cycles
//   if_flush      out  (FLUSH_ON_TAKEN_EN only) squash the IF/ID instruction
// -----------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int TNEW_W      = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ext_stall,
    input  logic [2:0]             id_branch_op,
    input  logic                   id_judge,
    input  logic [4:0]             id_rs_addr,
    input  logic [4:0]             id_rt_addr,
    input  logic [31:0]            id_rs_val,
    input  logic [31:0]            id_rt_val,
    input  logic                   id_wr_en,
    input  logic [4:0]             id_wr_addr,
    input  logic [TNEW_W-1:0]      id_tnew,
    output logic                   stall,
    output logic                   branch_taken,
    output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef FLUSH_ON_TAKEN_EN
    ,
    output logic                   if_flush
`endif
);

    import branch_pkg::*;

    // Scoreboard: sb_ex_p1 mirrors the instruction in EX, sb_mem_p2 the one
    // in MEM. Writers leaving MEM are dropped; WB reaches ID through the
    // register file's write-before-read path.
    sb_entry_t sb_ex_p1;
    sb_entry_t sb_mem_p2;
    sb_entry_t ex_next;
    sb_entry_t mem_next;

    logic is_branch;
    logic uses_rt;
    logic rs_blocked;
    logic rt_blocked;
    logic cond;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x != '0) ? (x - TNEW_W'(1)) : '0;
    endfunction

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] x);
        return (&x) ? x : (x + STALL_CNT_W'(1));
    endfunction

    // An entry blocks an operand only while its value is still in flight.
    // $0 never blocks: it is hard-wired and never written.
    function automatic logic entry_blocks(input sb_entry_t ent, input logic [4:0] addr);
        return ent.valid && (ent.tnew != '0) && (addr != 5'd0) && (ent.dst == addr);
    endfunction

    // ---- ID stage: hazard detect and branch resolve ----
    assign is_branch  = br_is_branch(id_branch_op);
    assign uses_rt    = br_uses_rt(id_branch_op);
    assign rs_blocked = entry_blocks(sb_ex_p1, id_rs_addr) || entry_blocks(sb_mem_p2, id_rs_addr);
    assign rt_blocked = uses_rt &&
                        (entry_blocks(sb_ex_p1, id_rt_addr) || entry_blocks(sb_mem_p2, id_rt_addr));

    // stall is not gated by ext_stall so the pipe stays held consistently
    // when the freeze lifts.
    assign stall = is_branch && (rs_blocked || rt_blocked);

    branch_cond u_cond (
        .op    (id_branch_op),
        .judge (id_judge),
        .rs    (id_rs_val),
        .rt    (id_rt_val),
        .cond  (cond)
    );

    assign branch_taken = cond && !stall && !ext_stall;

`ifdef FLUSH_ON_TAKEN_EN
    assign if_flush = branch_taken;
`endif

    always_comb begin
        // EX always ages into MEM, whether or not ID is stalled.
        mem_next       = '0;
        mem_next.valid = sb_ex_p1.valid;
        mem_next.dst   = sb_ex_p1.dst;
        mem_next.tnew  = sat_dec(sb_ex_p1.tnew);

        // A stalled ID sends a bubble into EX; otherwise the ID instruction
        // enters EX. Writes to $0 are not tracked.
        ex_next = '0;
        if (!stall) begin
            ex_next.valid = id_wr_en && (id_wr_addr != 5'd0);
            ex_next.dst   = id_wr_addr;
            ex_next.tnew  = id_tnew;
        end
    end

    // ---- ID -> EX (p1) -> MEM (p2) boundary ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_ex_p1     <= '0;
            sb_mem_p2    <= '0;
            stall_cycles <= '0;
        end else if (!ext_stall) begin
            sb_ex_p1  <= ex_next;
            sb_mem_p2 <= mem_next;
            if (stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_stall = 1'b0;
    logic [2:0]  id_branch_op = 3'd0;
    logic        id_judge = 1'b0;
    logic [4:0]  id_rs_addr = 5'd0;
    logic [4:0]  id_rt_addr = 5'd0;
    logic [31:0] id_rs_val = 32'd0;
    logic [31:0] id_rt_val = 32'd0;
    logic        id_wr_en = 1'b0;
    logic [4:0]  id_wr_addr = 5'd0;
    logic [1:0]  id_tnew = 2'd0;
    logic        stall;
    logic        branch_taken;
    logic [15:0] stall_cycles;
`ifdef FLUSH_ON_TAKEN_EN
    logic        if_flush;
`endif

    int checks = 0;
    int errors = 0;

    branch_hazard_ctrl #(.STALL_CNT_W(16), .TNEW_W(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ext_stall    (ext_stall),
        .id_branch_op (id_branch_op),
        .id_judge     (id_judge),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_val    (id_rs_val),
        .id_rt_val    (id_rt_val),
        .id_wr_en     (id_wr_en),
        .id_wr_addr   (id_wr_addr),
        .id_tnew      (id_tnew),
        .stall        (stall),
        .branch_taken (branch_taken),
        .stall_cycles (stall_cycles)
`ifdef FLUSH_ON_TAKEN_EN
        ,
        .if_flush     (if_flush)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: every tracked writer remembers the model time at which
    // it entered EX. It sits in EX at age 0 and MEM at age 1, is gone at
    // age 2, and blocks a branch operand while age < tnew. Model time
    // advances on every unfrozen edge, stalled or not.
    typedef struct {
        logic [4:0] dst;
        int         t0;
        int         tnew;
    } prod_t;

    prod_t prods[$];
    int    mt = 0;
    int    mcnt = 0;
    logic  obs_stall;
    logic  obs_taken;

    function automatic logic m_hazard();
        logic urt;
        if (id_branch_op < 3'd1 || id_branch_op > 3'd5) return 1'b0;
        urt = (id_branch_op == 3'd4) || (id_branch_op == 3'd5);
        foreach (prods[i]) begin
            int age;
            age = mt - prods[i].t0;
            if (age < 2 && age < prods[i].tnew &&
                (prods[i].dst == id_rs_addr || (urt && prods[i].dst == id_rt_addr)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic m_cond();
        logic signed [31:0] a;
        logic signed [31:0] b;
        a = id_rs_val;
        b = id_rt_val;
        case (id_branch_op)
            3'd1:    return id_judge ? (a >= 0) : (a < 0);
            3'd2:    return a > 0;
            3'd3:    return a <= 0;
            3'd4:    return a != b;
            3'd5:    return a == b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        prods.delete();
        mcnt = 0;
    endtask

    task automatic m_advance(input logic hz);
        if (ext_stall) return;
        if (hz) begin
            if (mcnt < 65535) mcnt++;
        end else if (id_wr_en && id_wr_addr != 5'd0) begin
            prods.push_back('{id_wr_addr, mt + 1, int'(id_tnew)});
        end
        mt++;
        for (int i = prods.size() - 1; i >= 0; i--)
            if (mt - prods[i].t0 >= 2) prods.delete(i);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then let the
    // model follow the active edge.
    task automatic tick(input string tag);
        logic eh;
        logic et;
        @(negedge clk);
        eh = m_hazard();
        et = m_cond() && !eh && !ext_stall;
        obs_stall = stall;
        obs_taken = branch_taken;
        chkb({tag, ".stall"}, stall, eh);
        chkb({tag, ".taken"}, branch_taken, et);
        chkv({tag, ".cnt"}, 32'(stall_cycles), 32'(mcnt));
`ifdef FLUSH_ON_TAKEN_EN
        chkb({tag, ".flush"}, if_flush, et);
`endif
        @(posedge clk);
        if (!reset_n) m_reset();
        else m_advance(eh);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic jd,
                         input logic [4:0] rsa, input logic [4:0] rta,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input logic we, input logic [4:0] wa, input logic [1:0] tn);
        id_branch_op = op;
        id_judge     = jd;
        id_rs_addr   = rsa;
        id_rt_addr   = rta;
        id_rs_val    = rsv;
        id_rt_val    = rtv;
        id_wr_en     = we;
        id_wr_addr   = wa;
        id_tnew      = tn;
    endtask

    // Hold the branch in ID until it stops stalling; bounded.
    task automatic hold(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick(tag);
            if (!obs_stall) break;
            n++;
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'd10;
        endcase
    endfunction

    initial begin
        int n;
        int first;
        logic [31:0] v;

        // Reset with a taken beq already sitting in ID.
        m_reset();
        drive(3'd5, 1'b0, 5'd8, 5'd8, 32'h1234, 32'h1234, 1'b0, 5'd0, 2'd0);
        repeat (2) begin
            @(negedge clk);
            chkb("rst.stall", stall, 1'b0);
            chkv("rst.cnt", 32'(stall_cycles), 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick("rel");
        chkb("rel.taken1", obs_taken, 1'b1);

        // ALU producer immediately ahead.
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd8, 2'd1);
        tick("addu");
        drive(3'd5, 1'b0, 5'd8, 5'd9, 32'd5, 32'd5, 1'b0, 5'd0, 2'd0);
        hold("alu", n);
        chkv("alu.nstall", 32'(n), 32'd1);
        chkb("alu.taken", obs_taken, 1'b1);
        chkv("alu.cnt", 32'(stall_cycles), 32'd1);

        // Load producer immediately ahead.
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd8, 2'd2);
        tick("lw");
        drive(3'd4, 1'b0, 5'd0, 5'd8, 32'd0, 32'd7, 1'b0, 5'd0, 2'd0);
        hold("load", n);
        chkv("load.nstall", 32'(n), 32'd2);
        chkv("load.cnt", 32'(stall_cycles), 32'd3);

        // Load two instructions ahead.
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd9, 2'd2);
        tick("lw2");
        drive(3'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'd0);
        tick("nop");
        drive(3'd5, 1'b0, 5'd9, 5'd0, 32'd3, 32'd4, 1'b0, 5'd0, 2'd0);
        hold("load2", n);
        chkv("load2.nstall", 32'(n), 32'd1);
        chkb("load2.taken", obs_taken, 1'b0);

        // Signed compares and $0.
        drive(3'd2, 1'b0, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 2'd0);
        tick("bgtz");
        chkb("bgtz.neg", obs_taken, 1'b0);
        drive(3'd1, 1'b0, 5'd1, 5'd0, 32'h8000_0000, 32'd0, 1'b0, 5'd0, 2'd0);
        tick("bltz");
        chkb("bltz.min", obs_taken, 1'b1);
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd0, 2'd2);
        tick("lw0");
        drive(3'd5, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'd0);
        tick("beq0");
        chkb("beq0.stall", obs_stall, 1'b0);
        chkb("beq0.taken", obs_taken, 1'b1);

        // ext_stall in the middle of a load hazard.
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd8, 2'd2);
        tick("xlw");
        drive(3'd4, 1'b0, 5'd0, 5'd8, 32'd1, 32'd2, 1'b0, 5'd0, 2'd0);
        tick("xbne");
        first = obs_stall ? 1 : 0;
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("xfrz");
            chkb("xfrz.taken", obs_taken, 1'b0);
        end
        chkv("xfrz.cnt", 32'(stall_cycles), 32'd5);
        ext_stall = 1'b0;
        hold("xrel", n);
        chkv("ext.total", 32'(first + n), 32'd2);
        chkv("ext.cnt", 32'(stall_cycles), 32'd6);

        // Reset asserted while a hazard stall is active.
        drive(3'd0, 1'b0, 5'd1, 5'd2, 32'd0, 32'd0, 1'b1, 5'd8, 2'd2);
        tick("rlw");
        drive(3'd4, 1'b0, 5'd0, 5'd8, 32'd1, 32'd2, 1'b0, 5'd0, 2'd0);
        tick("rbne");
        chkb("rbne.stall", obs_stall, 1'b1);
        reset_n = 1'b0;
        #1;
        chkb("rmid.stall", stall, 1'b0);
        chkv("rmid.cnt", 32'(stall_cycles), 32'd0);
        m_reset();
        tick("rheld");
        reset_n = 1'b1;
        tick("rpost");
        chkb("rpost.stall", obs_stall, 1'b0);

        // Taken beq with equal operands (flush output when built in).
        drive(3'd5, 1'b0, 5'd5, 5'd5, 32'd5, 32'd5, 1'b0, 5'd0, 2'd0);
        tick("flush");
        chkb("flush.taken", obs_taken, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v = pick_val();
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  pick_reg(), pick_reg(), v,
                  ($urandom_range(0, 2) == 0) ? v : pick_val(),
                  1'($urandom_range(0, 1)), pick_reg(), 2'($urandom_range(0, 3)));
            ext_stall = ($urandom_range(0, 7) == 0);
            tick("rnd");
        end
        ext_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
